// File: rtl/phase_timer.sv
// N-channel phase-duration timer: one-hot load, per-channel programmable limits, pause and abort.
// Optional tick prescaler enabled by defining PHASE_TIMER_PRESCALE_EN.
module phase_timer #(
  parameter int unsigned         NCH        = 4,
  parameter int unsigned         CW         = 32,
  parameter int unsigned         CHW        = 2,
  parameter logic [NCH*CW-1:0]   LIMIT_INIT = {32'd20, 32'd20, 32'd30, 32'd3},
  parameter int unsigned         PRESCALE   = 100_000_000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ld,
  input  logic [NCH-1:0]  sel,
  input  logic            abort,
  input  logic            pause,
  input  logic            cfg_we,
  input  logic [CHW-1:0]  cfg_ch,
  input  logic [CW-1:0]   cfg_val,
  output logic            busy,
  output logic [NCH-1:0]  active,
  output logic [CW-1:0]   remaining,
  output logic [NCH-1:0]  done,
  output logic            sel_err
);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  state_e         state;
  logic [CW-1:0]  limit [NCH];
  logic           sel_ok;
  logic [CHW-1:0] sel_idx;
  logic           start;
  logic           run_en;
  logic           tick;

  assign sel_ok = (sel != '0) && ((sel & (sel - NCH'(1))) == '0);
  assign start  = (state == StIdle) && ld && !abort && sel_ok;
  assign run_en = (state != StIdle) && !pause && !abort;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sel[i]) sel_idx = CHW'(i);
    end
  end

`ifdef PHASE_TIMER_PRESCALE_EN
  localparam int unsigned PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PSW-1:0] psc;

  assign tick = run_en && (psc == PSW'(PRESCALE - 1));

  // Frozen outside RUN so a resumed phase continues the partial tick period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      psc <= '0;
    end else if (start) begin
      psc <= '0;
    end else if (run_en) begin
      psc <= tick ? '0 : psc + PSW'(1);
    end
  end
`else
  logic [31:0] unused_prescale;

  assign unused_prescale = PRESCALE;
  assign tick            = run_en;
`endif

  // Indices that do not decode to a channel simply match no register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) limit[i] <= LIMIT_INIT[i*CW +: CW];
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cfg_we && (cfg_ch == CHW'(i))) limit[i] <= cfg_val;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= StIdle;
      busy      <= 1'b0;
      active    <= '0;
      remaining <= '0;
      done      <= '0;
      sel_err   <= 1'b0;
    end else begin
      done    <= '0;
      sel_err <= 1'b0;
      unique case (state)
        StIdle: begin
          if (ld && !abort) begin
            if (sel_ok) begin
              state     <= StRun;
              busy      <= 1'b1;
              active    <= sel;
              remaining <= limit[sel_idx];
            end else begin
              sel_err <= 1'b1;
            end
          end
        end
        StRun, StHold: begin
          if (abort) begin
            state     <= StIdle;
            busy      <= 1'b0;
            active    <= '0;
            remaining <= '0;
          end else if (pause) begin
            state <= StHold;
          end else begin
            state <= StRun;
            if (tick) begin
              if (remaining == '0) begin
                state  <= StIdle;
                busy   <= 1'b0;
                done   <= active;
                active <= '0;
              end else begin
                remaining <= remaining - CW'(1);
              end
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
